// File: rtl/ula_scheduler.sv
// Round-robin scheduler sharing one combinational add/multiply unit between two requesters.
// Registers the unit inputs, waits ALU_LAT cycles, then returns the result to the owner.
module ula_scheduler #(
   parameter int WIDTH   = 16,
   parameter int ALU_LAT = 1   // legal range 1..15
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0,
   input  logic             op0,
   input  logic [WIDTH-1:0] a0,
   input  logic [WIDTH-1:0] b0,
   output logic             ack0,
   output logic             done0,
   output logic [WIDTH-1:0] res0,
   input  logic             req1,
   input  logic             op1,
   input  logic [WIDTH-1:0] a1,
   input  logic [WIDTH-1:0] b1,
   output logic             ack1,
   output logic             done1,
   output logic [WIDTH-1:0] res1,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic             alu_sel,
   input  logic [WIDTH-1:0] alu_y,
   output logic             busy
);

   typedef enum logic {IDLE, EXEC} state_t;

   localparam logic [3:0] CNT_INIT = 4'(ALU_LAT - 1);

   state_t           state_q, state_d;
   logic             rr_q, rr_d;
   logic             owner_q, owner_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
   logic             alu_sel_q, alu_sel_d;
   logic             ack0_q, ack0_d, ack1_q, ack1_d;
   logic             done0_q, done0_d, done1_q, done1_d;
   logic [WIDTH-1:0] res0_q, res0_d, res1_q, res1_d;
   logic             win;

   always_comb begin
      state_d   = state_q;
      rr_d      = rr_q;
      owner_d   = owner_q;
      cnt_d     = cnt_q;
      alu_a_d   = alu_a_q;
      alu_b_d   = alu_b_q;
      alu_sel_d = alu_sel_q;
      res0_d    = res0_q;
      res1_d    = res1_q;
      ack0_d    = 1'b0;
      ack1_d    = 1'b0;
      done0_d   = 1'b0;
      done1_d   = 1'b0;
      // rr_q only matters on a tie; a lone request always wins
      win       = (req0 && req1) ? rr_q : req1;
      case (state_q)
         IDLE: begin
            if (req0 || req1) begin
               owner_d   = win;
               alu_a_d   = win ? a1 : a0;
               alu_b_d   = win ? b1 : b0;
               alu_sel_d = win ? op1 : op0;
               ack0_d    = ~win;
               ack1_d    = win;
               cnt_d     = CNT_INIT;
               state_d   = EXEC;
            end
         end
         EXEC: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               if (owner_q) begin
                  res1_d  = alu_y;
                  done1_d = 1'b1;
               end else begin
                  res0_d  = alu_y;
                  done0_d = 1'b1;
               end
               rr_d    = ~owner_q;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         rr_q      <= 1'b0;
         owner_q   <= 1'b0;
         cnt_q     <= 4'd0;
         alu_a_q   <= '0;
         alu_b_q   <= '0;
         alu_sel_q <= 1'b0;
         ack0_q    <= 1'b0;
         ack1_q    <= 1'b0;
         done0_q   <= 1'b0;
         done1_q   <= 1'b0;
         res0_q    <= '0;
         res1_q    <= '0;
      end else begin
         state_q   <= state_d;
         rr_q      <= rr_d;
         owner_q   <= owner_d;
         cnt_q     <= cnt_d;
         alu_a_q   <= alu_a_d;
         alu_b_q   <= alu_b_d;
         alu_sel_q <= alu_sel_d;
         ack0_q    <= ack0_d;
         ack1_q    <= ack1_d;
         done0_q   <= done0_d;
         done1_q   <= done1_d;
         res0_q    <= res0_d;
         res1_q    <= res1_d;
      end
   end

   assign alu_a   = alu_a_q;
   assign alu_b   = alu_b_q;
   assign alu_sel = alu_sel_q;
   assign ack0    = ack0_q;
   assign ack1    = ack1_q;
   assign done0   = done0_q;
   assign done1   = done1_q;
   assign res0    = res0_q;
   assign res1    = res1_q;
   assign busy    = (state_q == EXEC);

endmodule

// File: tb/tb_ula_scheduler.sv
// Directed bench: two schedulers (ALU_LAT=1 and ALU_LAT=3), each with its own behavioural shared unit.
module tb_ula_scheduler;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // ALU_LAT=1 instance
   logic        req0, op0, req1, op1, ack0, ack1, done0, done1, alu_sel, busy;
   logic [15:0] a0, b0, a1, b1, res0, res1, alu_a, alu_b, alu_y;
   logic [31:0] prod;
   assign prod  = alu_a * alu_b;
   assign alu_y = alu_sel ? prod[15:0] : alu_a + alu_b;

   ula_scheduler #(.WIDTH(16), .ALU_LAT(1)) u1 (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .op0(op0), .a0(a0), .b0(b0), .ack0(ack0), .done0(done0), .res0(res0),
      .req1(req1), .op1(op1), .a1(a1), .b1(b1), .ack1(ack1), .done1(done1), .res1(res1),
      .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_y(alu_y), .busy(busy));

   // ALU_LAT=3 instance
   logic        req0_3, op0_3, req1_3, op1_3, ack0_3, ack1_3, done0_3, done1_3, alu_sel_3, busy_3;
   logic [15:0] a0_3, b0_3, a1_3, b1_3, res0_3, res1_3, alu_a_3, alu_b_3, alu_y_3;
   logic [31:0] prod_3;
   assign prod_3  = alu_a_3 * alu_b_3;
   assign alu_y_3 = alu_sel_3 ? prod_3[15:0] : alu_a_3 + alu_b_3;

   ula_scheduler #(.WIDTH(16), .ALU_LAT(3)) u3 (
      .clk(clk), .rst_n(rst_n),
      .req0(req0_3), .op0(op0_3), .a0(a0_3), .b0(b0_3), .ack0(ack0_3), .done0(done0_3), .res0(res0_3),
      .req1(req1_3), .op1(op1_3), .a1(a1_3), .b1(b1_3), .ack1(ack1_3), .done1(done1_3), .res1(res1_3),
      .alu_a(alu_a_3), .alu_b(alu_b_3), .alu_sel(alu_sel_3), .alu_y(alu_y_3), .busy(busy_3));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      {req0, op0, req1, op1} = '0;
      {a0, b0, a1, b1} = '0;
      {req0_3, op0_3, req1_3, op1_3} = '0;
      {a0_3, b0_3, a1_3, b1_3} = '0;
      #12;
      chk("rst_busy", busy, 0);
      chk("rst_ack", {ack0, ack1}, 0);
      chk("rst_done", {done0, done1}, 0);
      chk("rst_res", {res0, res1}, 0);
      chk("rst_alu", {alu_a, alu_b}, 0);
      chk("rst_sel", alu_sel, 0);
      rst_n = 1'b1;

      // add 2+3 on requester 0
      req0 = 1; a0 = 16'd2; b0 = 16'd3; op0 = 0;
      step();
      chk("add_ack0", {ack0, ack1}, 2'b10);
      chk("add_alu", {alu_a, alu_b}, {16'd2, 16'd3});
      chk("add_sel", alu_sel, 0);
      chk("add_busy", busy, 1);
      chk("add_nodone", done0, 0);
      req0 = 0;
      step();
      chk("add_done0", {done0, done1, ack0}, 3'b100);
      chk("add_res0", res0, 16'd5);
      chk("add_res1", res1, 16'd0);
      chk("add_idle", busy, 0);
      step();
      chk("add_done_pulse", done0, 0);
      chk("add_res0_hold", res0, 16'd5);

      // multiply on requester 1, twice
      req1 = 1; a1 = 16'd2; b1 = 16'd3; op1 = 1;
      step();
      chk("mul_ack1", {ack0, ack1}, 2'b01);
      chk("mul_sel", alu_sel, 1);
      req1 = 0;
      step();
      chk("mul_done1", {done0, done1}, 2'b01);
      chk("mul_res1", res1, 16'd6);
      req1 = 1; a1 = 16'd4; b1 = 16'd2;
      step();
      chk("mul2_ack1", ack1, 1);
      req1 = 0;
      step();
      chk("mul2_res1", res1, 16'd8);
      chk("mul2_done1", done1, 1);
      chk("mul2_res0_keep", res0, 16'd5);

      // contention, rr_ptr points at requester 0
      req0 = 1; a0 = 16'd4; b0 = 16'd2; op0 = 0;
      req1 = 1; a1 = 16'd4; b1 = 16'd2; op1 = 1;
      step();
      chk("con_ack0", {ack0, ack1}, 2'b10);
      req0 = 0;
      step();
      chk("con_done0", {done0, ack1}, 2'b10);
      chk("con_res0", res0, 16'd6);
      step();
      chk("con_ack1", {ack0, ack1, done0}, 3'b010);
      req1 = 0;
      step();
      chk("con_done1", done1, 1);
      chk("con_res1", res1, 16'd8);

      // wrap add on requester 0 leaves rr_ptr at requester 1
      req0 = 1; a0 = 16'hFFFF; b0 = 16'h0002; op0 = 0;
      step();
      req0 = 0;
      step();
      chk("wrap_add", res0, 16'h0001);

      // simultaneous pair now goes to requester 1 first
      req0 = 1; a0 = 16'h0100; b0 = 16'h0100; op0 = 1;
      req1 = 1; a1 = 16'h00FF; b1 = 16'h0101; op1 = 1;
      step();
      chk("pair_ack1", {ack0, ack1}, 2'b01);
      req1 = 0;
      step();
      chk("pair_done1", {done0, done1}, 2'b01);
      chk("wrap_mul_ffff", res1, 16'hFFFF);
      step();
      chk("pair_ack0", {ack0, ack1}, 2'b10);
      req0 = 0;
      step();
      chk("wrap_mul_zero", {done0, res0}, {1'b1, 16'h0000});

      // ALU_LAT=3: 7*6 with operand churn and a blocked req1 during EXEC
      req0_3 = 1; a0_3 = 16'd7; b0_3 = 16'd6; op0_3 = 1;
      step();
      chk("l3_ack0", {ack0_3, ack1_3, busy_3}, 3'b101);
      req0_3 = 0; a0_3 = 16'd9; b0_3 = 16'd9; op0_3 = 0;
      req1_3 = 1; a1_3 = 16'd1; b1_3 = 16'd1; op1_3 = 0;
      step();
      chk("l3_e1", {busy_3, done0_3, ack1_3}, 3'b100);
      chk("l3_alu_hold", {alu_a_3, alu_b_3}, {16'd7, 16'd6});
      step();
      chk("l3_e2", {busy_3, done0_3, ack1_3}, 3'b100);
      step();
      chk("l3_e3", {busy_3, done0_3, ack1_3}, 3'b010);
      chk("l3_res0", res0_3, 16'h002A);
      step();
      chk("l3_ack1", {ack1_3, busy_3}, 2'b11);
      req1_3 = 0;
      step();

      // asynchronous reset between edges while EXEC
      #2 rst_n = 1'b0;
      #1;
      chk("arst_busy", busy_3, 0);
      chk("arst_res", {res0_3, res1_3}, 0);
      chk("arst_alu", {alu_a_3, alu_b_3, 15'd0, alu_sel_3}, 0);
      chk("arst_flags", {ack0_3, ack1_3, done0_3, done1_3}, 0);
      step();
      step();
      chk("arst_nodone", {done0_3, done1_3}, 0);
      #3 rst_n = 1'b1;
      req1_3 = 1; a1_3 = 16'd5; b1_3 = 16'd5; op1_3 = 0;
      step();
      chk("post_ack1", {ack0_3, ack1_3}, 2'b01);
      req1_3 = 0;
      step();
      step();
      chk("post_wait", {busy_3, done1_3}, 2'b10);
      step();
      chk("post_done1", {busy_3, done1_3}, 2'b01);
      chk("post_res1", res1_3, 16'd10);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #20000;
      fails++;
      $display("FAIL timeout: observed no finish, required finish before 20000");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $fatal(1, "timeout");
   end

endmodule
